// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if -- request/response bundle for one data-memory requester.
//
// One instance per requester port of dmem_arbiter.
//   req    requester -> arbiter   access request, held until gnt is sampled high
//   we     requester -> arbiter   1 = write, 0 = read
//   addr   requester -> arbiter   word address (AW bits)
//   wdata  requester -> arbiter   write data (DW bits)
//   gnt    arbiter -> requester   request accepted this cycle
//   rvalid arbiter -> requester   read data valid (single-cycle pulse)
//   rdata  arbiter -> requester   read data, held between reads of this port
//
// Modports: master = requester side, slave = arbiter side.

interface dmem_arbiter_if #(
    parameter int AW = 7,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter -- shares one single-port 128x32 data SRAM (CEN/WEN/OEN/A/D/Q
// pin set, SRAM clocked on ~clk) between two requesters.
//
//   p0 : MIPS core load/store path, fixed priority
//   p1 : loader/DMA port, protected by a starvation guard that forces a
//        port-1 grant after MAX_CONSEC consecutive port-0 grants while it waits
//
// Ports:
//   clk, rst_n       system clock; asynchronous active-low reset
//   p0, p1           dmem_arbiter_if.slave request/response bundles
//   CEN, WEN, OEN    registered SRAM controls, active low
//   A, D             registered SRAM address / write data (hold when idle)
//   Q                SRAM read data, valid before the end of the access cycle
//
// Timing: grant in cycle N -> SRAM controls in N+1 -> read data captured at
// the edge ending N+1 -> rvalid pulse on the owning port during N+2.
//
// Optional build macro DMEM_ARB_STATS_EN adds stat_clr (sync clear input) and
// gcnt0/gcnt1, saturating 16-bit per-port grant counters.

module dmem_arbiter #(
    parameter int AW         = 7,
    parameter int DW         = 32,
    parameter int MAX_CONSEC = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave p0,
    dmem_arbiter_if.slave p1,
    output logic          CEN,
    output logic          WEN,
    output logic          OEN,
    output logic [AW-1:0] A,
    output logic [DW-1:0] D,
    input  logic [DW-1:0] Q
`ifdef DMEM_ARB_STATS_EN
    ,
    input  logic          stat_clr,
    output logic [15:0]   gcnt0,
    output logic [15:0]   gcnt1
`endif
);

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    localparam logic [3:0] MAX_CNT = 4'(MAX_CONSEC);

    logic          gnt0;
    logic          gnt1;
    logic          any_gnt;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    logic [3:0]    starve_cnt;
    logic [3:0]    starve_nxt;

    // Tag of the access currently at the SRAM: read pending and owning port.
    logic          tag_rd;
    port_e         tag_port;

    logic          rvalid0_q;
    logic          rvalid1_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    // Grants are combinational; rst_n gates them so nothing is accepted
    // while reset is held.
    always_comb begin
        gnt0      = rst_n && p0.req && !(p1.req && (starve_cnt == MAX_CNT));
        gnt1      = rst_n && p1.req && !gnt0;
        any_gnt   = gnt0 || gnt1;
        sel_we    = gnt1 ? p1.we    : p0.we;
        sel_addr  = gnt1 ? p1.addr  : p0.addr;
        sel_wdata = gnt1 ? p1.wdata : p0.wdata;
    end

    // Counts port-0 grants that port 1 has sat through; cleared as soon as
    // port 1 is served or stops asking.
    always_comb begin
        starve_nxt = starve_cnt;
        if (!p1.req || gnt1) begin
            starve_nxt = '0;
        end else if (gnt0 && (starve_cnt != MAX_CNT)) begin
            starve_nxt = starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_nxt;
        end
    end

    // SRAM control registers. A and D keep their last value on idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            CEN      <= 1'b1;
            WEN      <= 1'b1;
            OEN      <= 1'b1;
            A        <= '0;
            D        <= '0;
            tag_rd   <= 1'b0;
            tag_port <= PORT0;
        end else begin
            tag_rd   <= any_gnt && !sel_we;
            tag_port <= gnt1 ? PORT1 : PORT0;
            if (any_gnt) begin
                CEN <= 1'b0;
                WEN <= ~sel_we;
                OEN <= sel_we;
                A   <= sel_addr;
                D   <= sel_wdata;
            end else begin
                CEN <= 1'b1;
                WEN <= 1'b1;
                OEN <= 1'b1;
            end
        end
    end

    // Read return: Q is valid by the end of the access cycle, so it is
    // captured at that edge into the tagged port only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= tag_rd && (tag_port == PORT0);
            rvalid1_q <= tag_rd && (tag_port == PORT1);
            if (tag_rd && (tag_port == PORT0)) begin
                rdata0_q <= Q;
            end
            if (tag_rd && (tag_port == PORT1)) begin
                rdata1_q <= Q;
            end
        end
    end

    assign p0.gnt    = gnt0;
    assign p1.gnt    = gnt1;
    assign p0.rvalid = rvalid0_q;
    assign p1.rvalid = rvalid1_q;
    assign p0.rdata  = rdata0_q;
    assign p1.rdata  = rdata1_q;

`ifdef DMEM_ARB_STATS_EN
    // Saturating grant counters; a clear in the same cycle as a grant wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcnt0 <= '0;
            gcnt1 <= '0;
        end else if (stat_clr) begin
            gcnt0 <= '0;
            gcnt1 <= '0;
        end else begin
            if (gnt0 && (gcnt0 != '1)) begin
                gcnt0 <= gcnt0 + 16'd1;
            end
            if (gnt1 && (gcnt1 != '1)) begin
                gcnt1 <= gcnt1 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter -- self-checking bench for dmem_arbiter.
// Includes a behavioural SRAM on ~clk, directed scenarios and a randomized
// run checked against a transaction-level reference model.

`timescale 1ns/1ps

module tb_dmem_arbiter;

    localparam int AW         = 7;
    localparam int DW         = 32;
    localparam int MAX_CONSEC = 4;

    logic          clk;
    logic          rst_n;
    logic          CEN, WEN, OEN;
    logic [AW-1:0] A;
    logic [DW-1:0] D;
    logic [DW-1:0] Q;
`ifdef DMEM_ARB_STATS_EN
    logic          stat_clr;
    logic [15:0]   gcnt0, gcnt1;
`endif

    dmem_arbiter_if #(.AW(AW), .DW(DW)) if0 ();
    dmem_arbiter_if #(.AW(AW), .DW(DW)) if1 ();

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_CONSEC(MAX_CONSEC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .p0       (if0),
        .p1       (if1),
        .CEN      (CEN),
        .WEN      (WEN),
        .OEN      (OEN),
        .A        (A),
        .D        (D),
        .Q        (Q)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_clr (stat_clr),
        .gcnt0    (gcnt0),
        .gcnt1    (gcnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM, clocked on the falling edge of clk.
    logic [DW-1:0] sram [0:127];
    always @(negedge clk) begin
        if (!CEN) begin
            if (!WEN)      sram[A] <= D;
            else if (!OEN) Q <= sram[A];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model state ----------------
    logic [DW-1:0] ref_mem [0:127];
    int            m_wait;       // port-0 grants port 1 has waited through
    logic          e0, e1;       // expected grants this cycle
    logic          st_rd, st_port;
    logic [DW-1:0] st_data;
    logic          m_rv0, m_rv1;
    logic [DW-1:0] m_rd0, m_rd1;
    logic          m_cen, m_wen, m_oen;
    logic [AW-1:0] m_a;
    logic [DW-1:0] m_d;

    // ---------------- observed values ----------------
    logic          o_g0, o_g1, o_rv0, o_rv1, o_cen, o_wen, o_oen;
    logic [DW-1:0] o_rd0, o_rd1, o_d;
    logic [AW-1:0] o_a;

    task automatic model_reset();
        m_wait  = 0;
        st_rd   = 1'b0;
        st_port = 1'b0;
        st_data = '0;
        m_rv0   = 1'b0;
        m_rv1   = 1'b0;
        m_rd0   = '0;
        m_rd1   = '0;
        m_cen   = 1'b1;
        m_wen   = 1'b1;
        m_oen   = 1'b1;
        m_a     = '0;
        m_d     = '0;
    endtask

    task automatic drive_idle();
        if0.req = 1'b0; if0.we = 1'b0; if0.addr = '0; if0.wdata = '0;
        if1.req = 1'b0; if1.we = 1'b0; if1.addr = '0; if1.wdata = '0;
    endtask

    // One clock cycle: entered and left at posedge+1. Grants are sampled
    // before the edge; registered outputs just after it.
    task automatic step(input logic r0, input logic w0, input logic [AW-1:0] a0,
                        input logic [DW-1:0] d0,
                        input logic r1, input logic w1, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d1);
        logic          gw;
        logic [AW-1:0] ga;
        logic [DW-1:0] gd;
        if0.req = r0; if0.we = w0; if0.addr = a0; if0.wdata = d0;
        if1.req = r1; if1.we = w1; if1.addr = a1; if1.wdata = d1;
        e0 = r0 && !(r1 && (m_wait >= MAX_CONSEC));
        e1 = r1 && !e0;
        #3;
        o_g0 = if0.gnt;
        o_g1 = if1.gnt;
        @(posedge clk);
        #1;
        o_rv0 = if0.rvalid; o_rv1 = if1.rvalid;
        o_rd0 = if0.rdata;  o_rd1 = if1.rdata;
        o_cen = CEN; o_wen = WEN; o_oen = OEN; o_a = A; o_d = D;
        // read granted last cycle returns now
        m_rv0 = st_rd && !st_port;
        m_rv1 = st_rd && st_port;
        if (m_rv0) m_rd0 = st_data;
        if (m_rv1) m_rd1 = st_data;
        gw = e1 ? w1 : w0;
        ga = e1 ? a1 : a0;
        gd = e1 ? d1 : d0;
        st_rd   = (e0 || e1) && !gw;
        st_port = e1;
        if (e0 || e1) begin
            m_cen = 1'b0; m_wen = !gw; m_oen = gw; m_a = ga; m_d = gd;
            if (gw) ref_mem[ga] = gd;
            else    st_data = ref_mem[ga];
        end else begin
            m_cen = 1'b1; m_wen = 1'b1; m_oen = 1'b1;
        end
        if (r1 && e0) begin
            if (m_wait < MAX_CONSEC) m_wait++;
        end else begin
            m_wait = 0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        if0.req = 1'b1; if0.we = 1'b0; if0.addr = 7'd3; if0.wdata = '0;
        if1.req = 1'b1; if1.we = 1'b1; if1.addr = 7'd5; if1.wdata = 32'h1234;
        #3;
        n_checks++;
        if ({if0.gnt, if1.gnt} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_gnt: got %b expected 00", {if0.gnt, if1.gnt});
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({CEN, WEN, OEN, A, D} !== {3'b111, 7'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_sram_pins: got CEN/WEN/OEN=%b A=%h D=%h expected 111 0 0",
                     {CEN, WEN, OEN}, A, D);
        end
        n_checks++;
        if ({if0.rvalid, if1.rvalid, if0.rdata, if1.rdata} !== {2'b00, 64'd0}) begin
            n_fail++;
            $display("FAIL reset_resp: got rvalid=%b rdata0=%h rdata1=%h expected 00 0 0",
                     {if0.rvalid, if1.rvalid}, if0.rdata, if1.rdata);
        end
        drive_idle();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_read_pair();
        sram[0] = 32'd15; ref_mem[0] = 32'd15;
        sram[1] = 32'd20; ref_mem[1] = 32'd20;
        sram[4] = 32'd99; ref_mem[4] = 32'd99;
        step(1'b1, 1'b0, 7'd0, '0, 1'b0, 1'b0, '0, '0);
        n_checks++;
        if ({o_g0, o_g1} !== 2'b10) begin
            n_fail++; $display("FAIL pair_gnt_a: got %b expected 10", {o_g0, o_g1});
        end
        step(1'b1, 1'b0, 7'd1, '0, 1'b0, 1'b0, '0, '0);
        n_checks++;
        if ({o_g0, o_g1, o_rv0, o_rd0} !== {3'b101, 32'd15}) begin
            n_fail++;
            $display("FAIL pair_first: got gnt=%b rvalid0=%b rdata0=%0d expected 10 1 15",
                     {o_g0, o_g1}, o_rv0, o_rd0);
        end
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        n_checks++;
        if ({o_rv0, o_rd0} !== {1'b1, 32'd20}) begin
            n_fail++;
            $display("FAIL pair_second: got rvalid0=%b rdata0=%0d expected 1 20", o_rv0, o_rd0);
        end
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        n_checks++;
        if ({o_rv0, o_rd0, o_cen} !== {1'b0, 32'd20, 1'b1}) begin
            n_fail++;
            $display("FAIL pair_hold: got rvalid0=%b rdata0=%0d CEN=%b expected 0 20 1",
                     o_rv0, o_rd0, o_cen);
        end
    endtask

    task automatic test_write_read_hazard();
        logic saw_rv1;
        saw_rv1 = 1'b0;
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 7'd4, 32'd30);
        saw_rv1 |= o_rv1;
        n_checks++;
        if ({o_g0, o_g1, o_cen, o_wen, o_oen, o_a, o_d} !== {2'b01, 3'b001, 7'd4, 32'd30}) begin
            n_fail++;
            $display("FAIL hazard_write: got gnt=%b ctl=%b A=%h D=%0d expected 01 001 4 30",
                     {o_g0, o_g1}, {o_cen, o_wen, o_oen}, o_a, o_d);
        end
        step(1'b1, 1'b0, 7'd4, '0, 1'b0, 1'b0, '0, '0);
        saw_rv1 |= o_rv1;
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        saw_rv1 |= o_rv1;
        n_checks++;
        if ({o_rv0, o_rd0} !== {1'b1, 32'd30}) begin
            n_fail++;
            $display("FAIL hazard_read: got rvalid0=%b rdata0=%0d expected 1 30", o_rv0, o_rd0);
        end
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        saw_rv1 |= o_rv1;
        n_checks++;
        if (saw_rv1 !== 1'b0) begin
            n_fail++; $display("FAIL hazard_no_rvalid1: got %b expected 0", saw_rv1);
        end
    endtask

    task automatic test_starvation(input int cycles);
        logic [1:0] exp_g;
        for (int k = 0; k < cycles; k++) begin
            step(1'b1, 1'b0, 7'd0, '0, 1'b1, 1'b0, 7'd1, '0);
            exp_g = ((k % (MAX_CONSEC + 1)) == MAX_CONSEC) ? 2'b01 : 2'b10;
            n_checks++;
            if ({o_g0, o_g1} !== exp_g) begin
                n_fail++;
                $display("FAIL starve_gnt[%0d]: got %b expected %b", k, {o_g0, o_g1}, exp_g);
            end
            n_checks++;
            if ({o_rv0, o_rv1, o_rd0, o_rd1} !== {m_rv0, m_rv1, m_rd0, m_rd1}) begin
                n_fail++;
                $display("FAIL starve_resp[%0d]: got rv=%b rd0=%h rd1=%h expected rv=%b rd0=%h rd1=%h",
                         k, {o_rv0, o_rv1}, o_rd0, o_rd1, {m_rv0, m_rv1}, m_rd0, m_rd1);
            end
        end
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
            n_checks++;
            if ({o_rv0, o_rv1, o_rd0, o_rd1} !== {m_rv0, m_rv1, m_rd0, m_rd1}) begin
                n_fail++;
                $display("FAIL starve_drain[%0d]: got rv=%b expected %b", k, {o_rv0, o_rv1},
                         {m_rv0, m_rv1});
            end
        end
    endtask

    task automatic test_port1_only();
        logic [AW-1:0] addrs [0:2];
        logic [DW-1:0] want  [0:4];
        logic          want_rv [0:4];
        addrs[0] = 7'd0; addrs[1] = 7'd1; addrs[2] = 7'd4;
        want[0] = 32'd0;  want[1] = 32'd15; want[2] = 32'd20; want[3] = 32'd30; want[4] = 32'd30;
        want_rv[0] = 1'b0; want_rv[1] = 1'b1; want_rv[2] = 1'b1; want_rv[3] = 1'b1; want_rv[4] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k < 3) step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, addrs[k], '0);
            else       step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
            n_checks++;
            if ({o_g1, o_cen} !== {(k < 3), !(k < 3)}) begin
                n_fail++;
                $display("FAIL p1only_gnt_cen[%0d]: got gnt1=%b CEN=%b expected %b %b",
                         k, o_g1, o_cen, (k < 3), !(k < 3));
            end
            if (k > 0) begin
                n_checks++;
                if ({o_rv1, o_rd1} !== {want_rv[k], want[k]}) begin
                    n_fail++;
                    $display("FAIL p1only_rdata[%0d]: got rvalid1=%b rdata1=%0d expected %b %0d",
                             k, o_rv1, o_rd1, want_rv[k], want[k]);
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        step(1'b1, 1'b0, 7'd1, '0, 1'b0, 1'b0, '0, '0);
        n_checks++;
        if ({o_g0, o_cen} !== 2'b10) begin
            n_fail++;
            $display("FAIL midop_grant: got gnt0=%b CEN=%b expected 1 0", o_g0, o_cen);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({CEN, WEN, OEN, if0.gnt} !== 4'b1110) begin
            n_fail++;
            $display("FAIL midop_abort: got CEN/WEN/OEN/gnt0=%b expected 1110",
                     {CEN, WEN, OEN, if0.gnt});
        end
        repeat (2) @(posedge clk);
        #1;
        drive_idle();
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
            n_checks++;
            if ({o_rv0, o_rv1, o_rd0, o_rd1, o_cen, o_a, o_d} !== {2'b00, 64'd0, 1'b1, 7'd0, 32'd0}) begin
                n_fail++;
                $display("FAIL midop_after[%0d]: got rv=%b rd0=%h rd1=%h CEN=%b A=%h D=%h expected 00 0 0 1 0 0",
                         k, {o_rv0, o_rv1}, o_rd0, o_rd1, o_cen, o_a, o_d);
            end
        end
        // a cleared starvation counter gives port 0 a full run first
        test_starvation(MAX_CONSEC + 1);
    endtask

    task automatic test_random(input int cycles);
        logic          pv0, pw0, pv1, pw1;
        logic [AW-1:0] pa0, pa1;
        logic [DW-1:0] pd0, pd1;
        pv0 = 1'b0; pv1 = 1'b0;
        pw0 = 1'b0; pw1 = 1'b0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
        for (int k = 0; k < cycles; k++) begin
            if (!pv0 && (k < cycles - 3) && ($urandom_range(0, 3) != 0)) begin
                pv0 = 1'b1; pw0 = 1'($urandom_range(0, 1));
                pa0 = 7'($urandom_range(0, 7)); pd0 = $urandom;
            end
            if (!pv1 && (k < cycles - 3) && ($urandom_range(0, 1) != 0)) begin
                pv1 = 1'b1; pw1 = 1'($urandom_range(0, 1));
                pa1 = 7'($urandom_range(0, 7)); pd1 = $urandom;
            end
            step(pv0, pw0, pa0, pd0, pv1, pw1, pa1, pd1);
            n_checks++;
            if ({o_g0, o_g1} !== {e0, e1}) begin
                n_fail++;
                $display("FAIL rand_gnt[%0d]: got %b expected %b", k, {o_g0, o_g1}, {e0, e1});
            end
            n_checks++;
            if ({o_cen, o_wen, o_oen, o_a, o_d} !== {m_cen, m_wen, m_oen, m_a, m_d}) begin
                n_fail++;
                $display("FAIL rand_sram[%0d]: got ctl=%b A=%h D=%h expected ctl=%b A=%h D=%h",
                         k, {o_cen, o_wen, o_oen}, o_a, o_d, {m_cen, m_wen, m_oen}, m_a, m_d);
            end
            n_checks++;
            if ({o_rv0, o_rv1, o_rd0, o_rd1} !== {m_rv0, m_rv1, m_rd0, m_rd1}) begin
                n_fail++;
                $display("FAIL rand_resp[%0d]: got rv=%b rd0=%h rd1=%h expected rv=%b rd0=%h rd1=%h",
                         k, {o_rv0, o_rv1}, o_rd0, o_rd1, {m_rv0, m_rv1}, m_rd0, m_rd1);
            end
            if (o_g0) pv0 = 1'b0;
            if (o_g1) pv1 = 1'b0;
        end
    endtask

`ifdef DMEM_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 7'(k), '0, 1'b0, 1'b0, '0, '0);
        for (int k = 0; k < 2; k++) step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 7'(k), '0);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        n_checks++;
        if ({gcnt0, gcnt1} !== {16'd5, 16'd2}) begin
            n_fail++;
            $display("FAIL stats_count: got gcnt0=%0d gcnt1=%0d expected 5 2", gcnt0, gcnt1);
        end
        stat_clr = 1'b1;
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        stat_clr = 1'b0;
        n_checks++;
        if ({gcnt0, gcnt1} !== 32'd0) begin
            n_fail++;
            $display("FAIL stats_clear: got gcnt0=%0d gcnt1=%0d expected 0 0", gcnt0, gcnt1);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
`ifdef DMEM_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        for (int i = 0; i < 128; i++) begin
            sram[i]    = $urandom;
            ref_mem[i] = sram[i];
        end
        model_reset();
        test_reset();
        test_read_pair();
        test_write_read_hazard();
        test_starvation(3 * (MAX_CONSEC + 1));
        test_port1_only();
        test_reset_midop();
        test_random(400);
`ifdef DMEM_ARB_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
